// File: rtl/chaos_pkg.sv
// Shared types and constants for the chaotic-map iteration sequencer.
package chaos_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;

   localparam int CH_X = 0;
   localparam int CH_Y = 1;
   localparam int CH_Z = 2;

endpackage

// File: rtl/chaos_result_collector.sv
// One result channel: sticky arrival flag plus the first value captured since the last clear.
module chaos_result_collector #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  stb,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  flag,
   output logic [DATA_WIDTH-1:0] dout
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag <= 1'b0;
      end else if (clr) begin
         flag <= 1'b0;
      end else if (stb) begin
         flag <= 1'b1;
      end
   end

   // Only the first strobe after a clear is kept; repeats leave the value untouched.
   always_ff @(posedge clk) begin
      if (!clr && stb && !flag) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/chaos_iter.sv
// Iteration sequencer: issues the state vector to the x/y/z units and feeds results back.
// Optional watchdog on WAIT/FLUSH enabled by defining CHAOS_ITER_WATCHDOG_EN.
module chaos_iter_ctrl
   import chaos_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ITER_W     = 32,
   parameter int WDOG_W     = 10,
   parameter int WDOG_LIMIT = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ITER_W-1:0]     iter_count,
   input  logic [DATA_WIDTH-1:0] x0,
   input  logic [DATA_WIDTH-1:0] y0,
   input  logic [DATA_WIDTH-1:0] z0,
   output logic                  eq_valid,
   output logic [DATA_WIDTH-1:0] eq_xn,
   output logic [DATA_WIDTH-1:0] eq_yn,
   output logic [DATA_WIDTH-1:0] eq_zn,
   input  logic                  xn1_valid,
   input  logic                  yn1_valid,
   input  logic                  zn1_valid,
   input  logic [DATA_WIDTH-1:0] xn1,
   input  logic [DATA_WIDTH-1:0] yn1,
   input  logic [DATA_WIDTH-1:0] zn1,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_x,
   output logic [DATA_WIDTH-1:0] out_y,
   output logic [DATA_WIDTH-1:0] out_z,
   output logic [ITER_W-1:0]     out_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(FP64_ZERO);

   state_t                state_q;
   logic [ITER_W-1:0]     idx_q;
   logic [ITER_W-1:0]     iter_n_q;
   logic [2:0]            stb;
   logic [2:0]            flag;
   logic [DATA_WIDTH-1:0] cap_x, cap_y, cap_z;
   logic                  in_collect;
   logic                  all_set;
   logic                  last;
   logic                  complete;
   logic                  clr;
   logic                  wd_hit;
   logic                  err_q;

   assign in_collect = (state_q == WAIT) || (state_q == FLUSH);
   assign stb[CH_X]  = xn1_valid && in_collect;
   assign stb[CH_Y]  = yn1_valid && in_collect;
   assign stb[CH_Z]  = zn1_valid && in_collect;
   assign all_set    = &flag;
   assign last       = (idx_q + ITER_W'(1)) == iter_n_q;
   assign complete   = (state_q == WAIT) && !abort && !wd_hit && all_set;
   // Flags are cleared whenever a new issue goes out to the units.
   assign clr        = (state_q == ISSUE) || (complete && !last);
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

   chaos_result_collector #(.DATA_WIDTH(DATA_WIDTH)) u_col_x (
      .clk(clk), .rst(rst), .clr(clr), .stb(stb[CH_X]), .din(xn1),
      .flag(flag[CH_X]), .dout(cap_x)
   );

   chaos_result_collector #(.DATA_WIDTH(DATA_WIDTH)) u_col_y (
      .clk(clk), .rst(rst), .clr(clr), .stb(stb[CH_Y]), .din(yn1),
      .flag(flag[CH_Y]), .dout(cap_y)
   );

   chaos_result_collector #(.DATA_WIDTH(DATA_WIDTH)) u_col_z (
      .clk(clk), .rst(rst), .clr(clr), .stb(stb[CH_Z]), .din(zn1),
      .flag(flag[CH_Z]), .dout(cap_z)
   );

`ifdef CHAOS_ITER_WATCHDOG_EN
   logic [WDOG_W-1:0] wd_q;

   assign wd_hit = in_collect && (wd_q == WDOG_W'(WDOG_LIMIT - 1));

   // Restarts on every entry into WAIT/FLUSH, including the in-place re-issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (!in_collect || ((state_q == WAIT) && (abort || wd_hit || all_set))) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + WDOG_W'(1);
      end
   end
`else
   logic unused_wdog;

   assign wd_hit      = 1'b0;
   assign unused_wdog = ^{WDOG_W, WDOG_LIMIT};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         iter_n_q  <= '0;
         eq_valid  <= 1'b0;
         eq_xn     <= ZERO;
         eq_yn     <= ZERO;
         eq_zn     <= ZERO;
         out_valid <= 1'b0;
         out_x     <= ZERO;
         out_y     <= ZERO;
         out_z     <= ZERO;
         out_idx   <= '0;
         done      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         eq_valid  <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  err_q <= 1'b0;
                  if (iter_count != '0) begin
                     eq_xn    <= x0;
                     eq_yn    <= y0;
                     eq_zn    <= z0;
                     idx_q    <= '0;
                     iter_n_q <= iter_count;
                     eq_valid <= 1'b1;
                     state_q  <= ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state_q <= abort ? FLUSH : WAIT;
            end
            WAIT: begin
               if (abort) begin
                  state_q <= FLUSH;
               end else if (wd_hit) begin
                  err_q   <= 1'b1;
                  state_q <= FLUSH;
               end else if (all_set) begin
                  out_valid <= 1'b1;
                  out_x     <= cap_x;
                  out_y     <= cap_y;
                  out_z     <= cap_z;
                  out_idx   <= idx_q;
                  eq_xn     <= cap_x;
                  eq_yn     <= cap_y;
                  eq_zn     <= cap_z;
                  if (last) begin
                     done    <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     idx_q    <= idx_q + ITER_W'(1);
                     eq_valid <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (all_set || wd_hit) begin
                  done    <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chaos_iter_ctrl.sv
// Randomized bench for chaos_iter_ctrl: the bench plays the three equation units and predicts
// every issued and completed state vector from the map rule it applies itself.
module tb_chaos_iter_ctrl;

   localparam int DW = 64;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [IW-1:0] iter_count;
   logic [DW-1:0] x0, y0, z0;
   logic          eq_valid;
   logic [DW-1:0] eq_xn, eq_yn, eq_zn;
   logic          xn1_valid, yn1_valid, zn1_valid;
   logic [DW-1:0] xn1, yn1, zn1;
   logic          out_valid;
   logic [DW-1:0] out_x, out_y, out_z;
   logic [IW-1:0] out_idx;
   logic          busy, done, err;

   chaos_iter_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .iter_count(iter_count),
      .x0(x0), .y0(y0), .z0(z0),
      .eq_valid(eq_valid), .eq_xn(eq_xn), .eq_yn(eq_yn), .eq_zn(eq_zn),
      .xn1_valid(xn1_valid), .yn1_valid(yn1_valid), .zn1_valid(zn1_valid),
      .xn1(xn1), .yn1(yn1), .zn1(zn1),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_idx(out_idx), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] x, y, z;
      int          idx;
   } res_t;

   res_t        exp_q[$];
   logic [63:0] m_x, m_y, m_z;
   int          issue_idx, run_n;
   bit          discard, in_flight, withhold_z;
   int          lat[3];
   int          due[3] = '{-1, -1, -1};
   logic [63:0] dval[3];
   int          dup_en = 0, dup_due = -1;
   logic [63:0] dup_val;
   int          pcyc = 0;
   int          last_stb_pcyc = 0, done_pcyc = 0, issue_pcyc = 0, err_pcyc = -1;
   int          done_cnt = 0, out_cnt = 0, eq_cnt = 0;
   logic [63:0] last_x, last_y, last_z, first_x, first_y, first_z;

   always @(posedge clk) pcyc++;

   // Equation-unit model and per-cycle output checker.
   always @(negedge clk) begin
      res_t e;
      bit   lst;
      xn1_valid = 1'b0;
      yn1_valid = 1'b0;
      zn1_valid = 1'b0;
      if (!rst) begin
         if (out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 1'b0);
            end else begin
               e   = exp_q.pop_front();
               lst = (e.idx == run_n - 1);
               chk("out_x", out_x, e.x);
               chk("out_y", out_y, e.y);
               chk("out_z", out_z, e.z);
               chk("out_idx", out_idx, e.idx);
               chk("out_latency", pcyc - last_stb_pcyc, 2);
               chk("done_with_last", done, lst);
               chk("eq_with_out", eq_valid, !lst);
            end
            in_flight = 1'b0;
            last_x = out_x; last_y = out_y; last_z = out_z;
         end
         if (eq_valid) begin
            chk("one_in_flight", in_flight, 1'b0);
            chk("eq_x", eq_xn, m_x);
            chk("eq_y", eq_yn, m_y);
            chk("eq_z", eq_zn, m_z);
            if (issue_idx == 0) begin
               first_x = eq_xn; first_y = eq_yn; first_z = eq_zn;
            end
            in_flight  = 1'b1;
            eq_cnt++;
            issue_pcyc = pcyc;
            m_x = m_x + 64'd1;
            m_y = m_y ^ 64'h8000_0000_0000_0000;
            m_z = m_z + 64'h10;
            exp_q.push_back('{m_x, m_y, m_z, issue_idx});
            issue_idx++;
            due[0] = pcyc + lat[0]; dval[0] = m_x;
            due[1] = pcyc + lat[1]; dval[1] = m_y;
            due[2] = withhold_z ? -1 : pcyc + lat[2]; dval[2] = m_z;
            if (dup_en != 0) begin
               dup_due = pcyc + lat[0] + 3;
               dup_val = ~m_x;
            end
         end
         if (done) begin
            done_cnt++;
            done_pcyc = pcyc;
            chk("busy_at_done", busy, 1'b0);
            if (discard) begin
               exp_q.delete();
               in_flight = 1'b0;
            end else begin
               chk("exp_drained", exp_q.size(), 0);
            end
         end
`ifndef CHAOS_ITER_WATCHDOG_EN
         chk("err_low", err, 1'b0);
`else
         if (err && err_pcyc < 0) err_pcyc = pcyc;
`endif
      end
      if (due[0] == pcyc) begin xn1_valid = 1'b1; xn1 = dval[0]; last_stb_pcyc = pcyc; end
      if (due[1] == pcyc) begin yn1_valid = 1'b1; yn1 = dval[1]; last_stb_pcyc = pcyc; end
      if (due[2] == pcyc) begin zn1_valid = 1'b1; zn1 = dval[2]; last_stb_pcyc = pcyc; end
      if (dup_due == pcyc) begin xn1_valid = 1'b1; xn1 = dup_val; end
   end

   task automatic do_run(input logic [63:0] sx, sy, sz, input int n, input int l0, l1, l2,
                         input int dupx, input bit ab, input bit disc, input int budget);
      int d0, o0, e0, start_pcyc;
      m_x = sx; m_y = sy; m_z = sz;
      issue_idx = 0; run_n = n; discard = disc;
      lat = '{l0, l1, l2}; dup_en = dupx;
      d0 = done_cnt; o0 = out_cnt; e0 = eq_cnt;
      @(negedge clk);
      start = 1'b1; iter_count = IW'(n); x0 = sx; y0 = sy; z0 = sz;
      start_pcyc = pcyc;
      @(negedge clk);
      start = 1'b0;
      if (ab) begin
         for (int i = 0; i < 100 && eq_cnt == e0; i++) @(negedge clk);
         repeat (10) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("one_done", done_cnt - d0, 1);
      chk("out_count", out_cnt - o0, disc ? 0 : n);
      if (n == 0) begin
         chk("zero_done_delay", done_pcyc - start_pcyc, 1);
         chk("zero_no_issue", eq_cnt - e0, 0);
      end
      if (ab) chk("flush_exit", done_pcyc - last_stb_pcyc, 2);
      dup_en = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; iter_count = '0;
      x0 = '0; y0 = '0; z0 = '0; xn1 = '0; yn1 = '0; zn1 = '0;
      withhold_z = 1'b0; discard = 1'b0; run_n = 0; issue_idx = 0;
      m_x = '0; m_y = '0; m_z = '0; lat = '{1, 1, 1};
      repeat (3) @(negedge clk);
      chk("rst_eq_valid", eq_valid, 1'b0);
      chk("rst_eq_xn", eq_xn, 64'h0);
      chk("rst_eq_zn", eq_zn, 64'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_x", out_x, 64'h0);
      chk("rst_out_idx", out_idx, 64'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Three iterations with staggered unit latencies.
      do_run(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
             3, 240, 250, 260, 0, 1'b0, 1'b0, 5000);
      chk("lit_t1_x", last_x, 64'h3FF0_0000_0000_0003);
      chk("lit_t1_y", last_y, 64'hC000_0000_0000_0000);
      chk("lit_t1_z", last_z, 64'h4008_0000_0000_0030);

      // All strobes in the same cycle.
      do_run(64'h1234, 64'h5678, 64'h9ABC, 2, 7, 7, 7, 0, 1'b0, 1'b0, 500);

      // Zero iterations.
      do_run(64'h1, 64'h2, 64'h3, 0, 5, 5, 5, 0, 1'b0, 1'b0, 50);
      chk("zero_busy", busy, 1'b0);

      // Abort during WAIT, results 200 cycles later; then a fresh run with 0.5 seeds.
      do_run(64'h4010_0000_0000_0000, 64'h4014_0000_0000_0000, 64'h4018_0000_0000_0000,
             5, 210, 210, 210, 0, 1'b1, 1'b1, 2000);
      do_run(64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000,
             1, 4, 6, 8, 0, 1'b0, 1'b0, 500);
      chk("lit_half_x", first_x, 64'h3FE0_0000_0000_0000);
      chk("lit_half_y", first_y, 64'h3FE0_0000_0000_0000);
      chk("lit_half_z", first_z, 64'h3FE0_0000_0000_0000);

      // Duplicate x strobe carrying a different value.
      do_run(64'h0, 64'h0, 64'h0, 1, 5, 30, 30, 1, 1'b0, 1'b0, 500);
      chk("lit_dup_x", last_x, 64'h1);
      chk("lit_dup_y", last_y, 64'h8000_0000_0000_0000);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         do_run({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(1, 4)), int'($urandom_range(1, 40)),
                int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                int'($urandom_range(0, 1)) * int'(r % 2), 1'b0, 1'b0, 1000);
      end

`ifdef CHAOS_ITER_WATCHDOG_EN
      // Withheld z result trips the watchdog; next start clears err.
      withhold_z = 1'b1;
      err_pcyc   = -1;
      do_run(64'h7, 64'h8, 64'h9, 1, 5, 5, 5, 0, 1'b0, 1'b1, 3000);
      chk("wd_err_set", err, 1'b1);
      chk("wd_err_timing", err_pcyc - issue_pcyc, 513);
      withhold_z = 1'b0;
      do_run(64'h7, 64'h8, 64'h9, 1, 5, 5, 5, 0, 1'b0, 1'b0, 500);
      chk("wd_err_cleared", err, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
